// File: rtl/gfx_sdr_arbiter_if.sv
// Bus bundle between the graphics ROM fetchers, gfx_sdr_arbiter and the SDRAM controller.
// master is the fetcher/SDRAM environment side, slave is the arbiter.
interface gfx_sdr_arbiter_if #(
   parameter int NCH = 4,
   parameter int AW  = 25,
   parameter int DW  = 16
);
   logic [NCH-1:0]    ch_req;
   logic [NCH*AW-1:0] ch_addr;
   logic [DW-1:0]     ch_data;
   logic [NCH-1:0]    ch_rdy;
   logic [AW-1:0]     sdr_addr;
   logic              sdr_req;
   logic              sdr_rdy;
   logic [DW-1:0]     sdr_data;

   modport master (
      output ch_req, ch_addr, sdr_rdy, sdr_data,
      input  ch_data, ch_rdy, sdr_addr, sdr_req
   );

   modport slave (
      input  ch_req, ch_addr, sdr_rdy, sdr_data,
      output ch_data, ch_rdy, sdr_addr, sdr_req
   );
endinterface

// File: rtl/gfx_sdr_arbiter.sv
// gfx_sdr_arbiter: holds one pending ROM read per graphics layer and serialises them onto one SDRAM port.
// Define GFX_SDR_ARB_RR_EN for round-robin grants; otherwise fixed priority with channel 0 highest.
module gfx_sdr_arbiter #(
   parameter int NCH     = 4,
   parameter int AW      = 25,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             RESETn,
   gfx_sdr_arbiter_if.slave bus,
   output logic             busy,
   output logic             timeout_err
);
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RETURN} state_t;

   state_t         state;
   state_t         state_nx;
   logic [NCH-1:0] pend;
   logic [AW-1:0]  addr_q [NCH];
   logic [GW-1:0]  gnt_q;
   logic [GW-1:0]  sel;
   logic           sel_vld;
   logic [CW-1:0]  wd_cnt;
   logic           grant;
   logic           done;
   logic           abort;
`ifdef GFX_SDR_ARB_RR_EN
   logic [GW-1:0]  rr_ptr;
`endif

   always_ff @(posedge clk) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = ISSUE;
         ISSUE:   if (done || abort) state_nx = RETURN;
         RETURN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Round-robin searches from the slot after the last grant; fixed priority always from channel 0.
   always_comb begin
      int idx;
      sel     = '0;
      sel_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < NCH; k++) begin
`ifdef GFX_SDR_ARB_RR_EN
         idx = (int'(rr_ptr) + 1 + k) % NCH;
`else
         idx = k;
`endif
         if (!sel_vld && pend[idx]) begin
            sel     = GW'(idx);
            sel_vld = 1'b1;
         end
      end
   end

   // A genuine sdr_rdy in the final watchdog cycle still wins over the abort.
   always_comb begin
      grant = (state == IDLE) && sel_vld;
      done  = (state == ISSUE) && bus.sdr_rdy;
      abort = (TIMEOUT != 0) && (state == ISSUE) && !bus.sdr_rdy &&
              (wd_cnt == CW'(TIMEOUT - 1));
   end

   assign busy = (state != IDLE) || (|pend);

   always_ff @(posedge clk) begin
      if (!RESETn) begin
         pend         <= '0;
         gnt_q        <= '0;
         wd_cnt       <= '0;
         timeout_err  <= 1'b0;
         bus.sdr_addr <= '0;
         bus.sdr_req  <= 1'b0;
         bus.ch_rdy   <= '0;
         bus.ch_data  <= '0;
         for (int i = 0; i < NCH; i++) addr_q[i] <= '0;
`ifdef GFX_SDR_ARB_RR_EN
         rr_ptr       <= GW'(NCH - 1);
`endif
      end else begin
         bus.ch_rdy <= '0;
         if (grant) begin
            bus.sdr_addr <= addr_q[sel];
            bus.sdr_req  <= 1'b1;
            gnt_q        <= sel;
            wd_cnt       <= '0;
            pend[sel]    <= 1'b0;
`ifdef GFX_SDR_ARB_RR_EN
            rr_ptr       <= sel;
`endif
         end
         if ((state == ISSUE) && !done && !abort) wd_cnt <= wd_cnt + CW'(1);
         if (done || abort) begin
            bus.sdr_req       <= 1'b0;
            bus.ch_data       <= done ? bus.sdr_data : {DW{1'b1}};
            bus.ch_rdy[gnt_q] <= 1'b1;
         end
         if (abort) timeout_err <= 1'b1;
         // Captures come last so a pulse in the grant cycle re-arms the channel with the new address.
         for (int i = 0; i < NCH; i++) begin
            if (bus.ch_req[i]) begin
               pend[i]   <= 1'b1;
               addr_q[i] <= bus.ch_addr[i*AW +: AW];
            end
         end
      end
   end
endmodule

// File: tb/tb_gfx_sdr_arbiter.sv
// Randomised scoreboard bench for gfx_sdr_arbiter with a transaction-level model of the arbiter.
// Expectations are queued by the driver and consumed by an independent negedge monitor.
module tb_gfx_sdr_arbiter;
   localparam int NCH     = 4;
   localparam int AW      = 25;
   localparam int DW      = 16;
   localparam int TIMEOUT = 8;

   logic clk = 1'b0;
   logic RESETn;
   logic busy;
   logic timeout_err;

   gfx_sdr_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

   gfx_sdr_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .RESETn(RESETn),
      .bus(bus),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          req;
      logic          bsy;
      logic          terr;
      logic          rdy;
      logic [DW-1:0] cdat;
   } stat_t;

   typedef struct packed {
      logic [7:0]    ch;
      logic [DW-1:0] data;
   } ret_t;

   stat_t         stat_q[$];
   ret_t          ret_q[$];
   logic [AW-1:0] iss_q[$];

   int checks = 0;
   int errors = 0;

   bit            m_pend [NCH];
   logic [AW-1:0] m_addr [NCH];
   bit            m_fly = 1'b0;
   int            m_ch = 0;
   int            m_iss = 0;
   int            m_edge = 0;
   int            m_free = 0;
   int            m_last = NCH - 1;
   bit            m_terr = 1'b0;
   logic [DW-1:0] m_cdat = '0;

   int            cur_lat = 1;
   int            fixed_lat = 0;
   int            lat_max = 6;
   int            stray_pct = 0;
   bit            fixed_data_en = 1'b0;
   logic [DW-1:0] fixed_data = '0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit any_pend();
      for (int i = 0; i < NCH; i++) if (m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pick();
      int idx;
      for (int k = 0; k < NCH; k++) begin
`ifdef GFX_SDR_ARB_RR_EN
         idx = (m_last + 1 + k) % NCH;
`else
         idx = k;
`endif
         if (m_pend[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NCH*AW-1:0] rand_addr();
      logic [NCH*AW-1:0] v;
      for (int i = 0; i < NCH; i++) v[i*AW +: AW] = AW'($urandom);
      return v;
   endfunction

   function automatic logic [NCH*AW-1:0] addr_vec(input logic [AW-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   // Drives one edge worth of inputs and advances the model to the state after that edge.
   task automatic apply_stimulus(input bit rstn, input logic [NCH-1:0] req,
                                 input logic [NCH*AW-1:0] addr, input bit rdy,
                                 input logic [DW-1:0] data);
      bit    done_now;
      int    g;
      stat_t s;
      ret_t  r;
      RESETn       = rstn;
      bus.ch_req   = req;
      bus.ch_addr  = addr;
      bus.sdr_rdy  = rdy;
      bus.sdr_data = data;
      m_edge++;
      done_now = 1'b0;
      if (!rstn) begin
         for (int i = 0; i < NCH; i++) m_pend[i] = 1'b0;
         m_fly  = 1'b0;
         m_free = m_edge + 1;
         m_terr = 1'b0;
         m_last = NCH - 1;
         m_cdat = '0;
      end else begin
         if (m_fly && (rdy || (m_edge - m_iss == TIMEOUT))) begin
            m_cdat = rdy ? data : '1;
            if (!rdy) m_terr = 1'b1;
            r.ch   = 8'(m_ch);
            r.data = m_cdat;
            ret_q.push_back(r);
            m_fly    = 1'b0;
            m_free   = m_edge + 2;
            done_now = 1'b1;
         end
         if (!m_fly && m_edge >= m_free) begin
            g = pick();
            if (g >= 0) begin
               iss_q.push_back(m_addr[g]);
               m_pend[g] = 1'b0;
               m_fly     = 1'b1;
               m_ch      = g;
               m_iss     = m_edge;
               m_last    = g;
               cur_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(lat_max, 1));
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (req[i]) begin
               m_pend[i] = 1'b1;
               m_addr[i] = addr[i*AW +: AW];
            end
         end
      end
      s.req  = m_fly;
      s.bsy  = m_fly || done_now || any_pend();
      s.terr = m_terr;
      s.rdy  = done_now;
      s.cdat = m_cdat;
      stat_q.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [NCH-1:0] req, input logic [NCH*AW-1:0] addr);
      bit            rdy;
      logic [DW-1:0] d;
      rdy = m_fly && (m_edge + 1 - m_iss == cur_lat);
      if (!m_fly && $urandom_range(99, 0) < stray_pct) rdy = 1'b1;
      d = DW'($urandom);
      if (rdy && fixed_data_en) d = fixed_data;
      apply_stimulus(1'b1, req, addr, rdy, d);
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, rand_addr());
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_fly || any_pend() || m_edge + 1 < m_free) && n < 300) begin
         step('0, rand_addr());
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got model still busy after %0d cycles, expected idle", n);
      end
      idle(2);
   endtask

   initial begin : monitor
      stat_t         s;
      ret_t          r;
      logic          prev_req;
      logic [AW-1:0] exp_addr;
      prev_req = 1'b0;
      exp_addr = '0;
      forever begin
         @(negedge clk);
         if (stat_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL status_underflow: got DUT cycle at t=%0t, expected a queued status", $time);
         end else begin
            s = stat_q.pop_front();
            check_output("sdr_req", 64'(bus.sdr_req), 64'(s.req));
            check_output("busy", 64'(busy), 64'(s.bsy));
            check_output("timeout_err", 64'(timeout_err), 64'(s.terr));
            check_output("ch_rdy_any", 64'(|bus.ch_rdy), 64'(s.rdy));
            check_output("ch_data", 64'(bus.ch_data), 64'(s.cdat));
         end
         if (bus.sdr_req && !prev_req) begin
            if (iss_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL issue_unexpected: got sdr_addr 0x%0h, expected no issue", bus.sdr_addr);
            end else begin
               exp_addr = iss_q.pop_front();
               check_output("sdr_addr", 64'(bus.sdr_addr), 64'(exp_addr));
            end
         end else if (bus.sdr_req) begin
            check_output("sdr_addr_hold", 64'(bus.sdr_addr), 64'(exp_addr));
         end
         if (bus.ch_rdy != '0) begin
            if (ret_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL return_unexpected: got ch_rdy 0x%0h, expected none", bus.ch_rdy);
            end else begin
               r = ret_q.pop_front();
               check_output("ch_rdy_onehot", 64'(bus.ch_rdy), 64'(1) << r.ch);
               check_output("ret_data", 64'(bus.ch_data), 64'(r.data));
            end
         end
         prev_req = bus.sdr_req;
      end
   end

   initial begin : guard
      #1_000_000;
      $display("[TB] FAIL global_timeout: got no end of stimulus, expected finish");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   initial begin : stimulus
      logic [NCH-1:0] rq;
      for (int i = 0; i < NCH; i++) begin
         m_pend[i] = 1'b0;
         m_addr[i] = '0;
      end
      repeat (3) apply_stimulus(1'b0, '0, '0, 1'b0, '0);

      $display("[TB] single request");
      fixed_lat = 5;
      fixed_data_en = 1'b1;
      fixed_data = 16'hBEEF;
      step(4'b0001, addr_vec(25'h0123456, 25'h0, 25'h0, 25'h0));
      drain();
      fixed_data_en = 1'b0;

      $display("[TB] simultaneous requests");
      fixed_lat = 2;
      step(4'b0010, addr_vec(25'h0, 25'h0AAAA1, 25'h0, 25'h0));
      drain();
      step(4'b1111, addr_vec(25'h1000A0, 25'h1000A1, 25'h1000A2, 25'h1000A3));
      drain();

      $display("[TB] overwrite while another channel is in flight");
      fixed_lat = 6;
      step(4'b0010, addr_vec(25'h0, 25'h0BBBB1, 25'h0, 25'h0));
      step(4'b0100, addr_vec(25'h0, 25'h0, 25'h100, 25'h0));
      step(4'b0100, addr_vec(25'h0, 25'h0, 25'h200, 25'h0));
      drain();

      $display("[TB] grant-cycle re-request");
      fixed_lat = 3;
      step(4'b1000, addr_vec(25'h0, 25'h0, 25'h0, 25'h333));
      step(4'b1000, addr_vec(25'h0, 25'h0, 25'h0, 25'h444));
      drain();

      $display("[TB] watchdog abort");
      fixed_lat = 99;
      step(4'b0001, addr_vec(25'h55, 25'h0, 25'h0, 25'h0));
      drain();
      idle(3);

      $display("[TB] reset mid-issue with late sdr_rdy");
      step(4'b0010, addr_vec(25'h0, 25'h66, 25'h0, 25'h0));
      idle(3);
      apply_stimulus(1'b0, '0, rand_addr(), 1'b0, '0);
      stray_pct = 100;
      idle(3);
      stray_pct = 0;

      $display("[TB] randomised traffic");
      for (int ph = 0; ph < 4; ph++) begin
         fixed_lat = 0;
         lat_max   = (ph == 2) ? 11 : 6;
         stray_pct = 10;
         for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCH; i++) rq[i] = ($urandom_range(99, 0) < 15);
            if ($urandom_range(999, 0) < 5) apply_stimulus(1'b0, '0, rand_addr(), 1'b0, '0);
            else                             step(rq, rand_addr());
         end
      end
      stray_pct = 0;
      drain();

      @(negedge clk);
      #1;
      check_output("issues_left", 64'(iss_q.size()), 64'(0));
      check_output("returns_left", 64'(ret_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
